// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath width and the {valid, data} stage
// bundle. The core's decode/execute payload structs build on these.
package pipe_pkg;

    localparam int PIPE_W = 32;

    typedef struct packed {
        logic              valid;
        logic [PIPE_W-1:0] data;
    } stage_t;

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register: a valid bit plus payload. It loads when told to
// advance, clears its valid bit on flush and exposes its next valid state
// so the parent can keep a registered occupancy count.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             adv,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             valid_nxt,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d,  data_q;

    // Next state: take upstream on advance; payload loads only for a real entry.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (adv) begin
            valid_d = in_valid;
            if (in_valid) begin
                data_d = in_data;
            end
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_nxt = valid_d;
    assign out_valid = valid_q;
    assign out_data  = data_q;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage valid/ready pipeline register chain with flush.
// ELASTIC=1 squeezes out bubbles (a stage moves when the one ahead is empty
// or moving); ELASTIC=0 stalls every stage together on output backpressure.
// out_ready reaches in_ready combinationally; in_valid never reaches out_valid.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH   = PIPE_W,
    parameter int DEPTH   = 2,
    parameter int ELASTIC = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int OCC_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] v_nxt;
    logic [DEPTH-1:0] adv;
    logic [WIDTH-1:0] stage_data [DEPTH];
    logic             in_acc;
    logic [OCC_W-1:0] occ_d, occ_q;

    // Advance chain: the last stage moves when empty or consumed; upstream
    // stages follow either the bubble-collapsing or the lock-step rule.
    always_comb begin
        adv            = '0;
        adv[DEPTH-1]   = !v[DEPTH-1] | out_ready;
        if (ELASTIC != 0) begin
            for (int i = DEPTH - 2; i >= 0; i--) begin
                adv[i] = !v[i] | adv[i+1];
            end
        end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                adv[i] = adv[DEPTH-1];
            end
        end
    end

    // A flush cycle never accepts input.
    assign in_ready = adv[0] & !flush;
    assign in_acc   = in_valid & in_ready;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .adv       (adv[g]),
                .flush     (flush),
                .in_valid  (in_acc),
                .in_data   (in_data),
                .valid_nxt (v_nxt[g]),
                .out_valid (v[g]),
                .out_data  (stage_data[g])
            );
        end else begin : g_body
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk       (clk),
                .reset     (reset),
                .adv       (adv[g]),
                .flush     (flush),
                .in_valid  (v[g-1]),
                .in_data   (stage_data[g-1]),
                .valid_nxt (v_nxt[g]),
                .out_valid (v[g]),
                .out_data  (stage_data[g])
            );
        end
    end

    // Popcount of the next valid vector, so occupancy lines up with v.
    always_comb begin
        occ_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_d = occ_d + OCC_W'(v_nxt[i]);
        end
    end

    // Occupancy register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;
    assign out_valid = v[DEPTH-1];
    assign out_data  = stage_data[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Bench for pipe_stage_chain: an elastic DEPTH=3 instance checked every
// cycle against a position-based reference model/scoreboard, plus a
// lock-step DEPTH=3 instance for the non-collapsing bubble behaviour.
module tb_pipe_stage_chain;

    localparam int W = 32;
    localparam int D = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         flush, in_valid, out_ready;
    logic [W-1:0] in_data;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    logic         ls_flush, ls_in_valid, ls_out_ready;
    logic [W-1:0] ls_in_data;
    logic         ls_in_ready, ls_out_valid;
    logic [W-1:0] ls_out_data;
    logic [1:0]   ls_occupancy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int t_in  = 0;
    bit lat_arm = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .ELASTIC(1)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .ELASTIC(0)) dut_ls (
        .clk(clk), .reset(reset), .flush(ls_flush),
        .in_valid(ls_in_valid), .in_ready(ls_in_ready), .in_data(ls_in_data),
        .out_valid(ls_out_valid), .out_ready(ls_out_ready), .out_data(ls_out_data),
        .occupancy(ls_occupancy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted word is an entry with a stage position.
    // The head races to the last stage; each follower moves up by one unless
    // it would land on (or pass) the entry in front of it.
    typedef struct {
        logic [W-1:0] d;
        int           pos;
    } ent_t;
    ent_t mq[$];

    always @(posedge clk or posedge reset) begin : model
        bit   acc;
        ent_t e;
        int   lim;
        int   nxt;
        if (reset) begin
            mq.delete();
        end else begin
            acc = in_valid && !flush && (mq.size() < D || out_ready);
            if (flush) begin
                mq.delete();
            end else begin
                for (int k = 0; k < mq.size(); k++) begin
                    lim = (k == 0) ? D - 1 : mq[k-1].pos - 1;
                    nxt = mq[k].pos + 1;
                    mq[k].pos = (nxt < lim) ? nxt : lim;
                end
                if (acc) begin
                    e.d   = in_data;
                    e.pos = 0;
                    mq.push_back(e);
                end
            end
        end
    end

    // Monitor: compare the elastic DUT with the model, pop the head on a
    // consumer handshake.
    always @(negedge clk) begin : monitor
        logic exp_ov;
        exp_ov = (mq.size() > 0) && (mq[0].pos == D - 1);
        check("occupancy", 32'(occupancy), 32'(mq.size()));
        check("out_valid", 32'(out_valid), 32'(exp_ov));
        check("in_ready", 32'(in_ready), 32'(!flush && (mq.size() < D || out_ready)));
        if (exp_ov) begin
            check("out_data", out_data, mq[0].d);
            if (lat_arm && mq[0].d == 32'hA0) begin
                check("latency", 32'(cyc - t_in), 32'd3);
                lat_arm = 1'b0;
            end
            if (out_ready) void'(mq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin : stim
        int acc_cnt;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        ls_flush = 1'b0; ls_in_valid = 1'b0; ls_in_data = '0; ls_out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_ov", 32'(out_valid), 32'd0);
        tick();
        reset = 1'b0;

        // Reset mid-stream with two entries in flight
        tick(); in_valid = 1'b1; in_data = 32'h1;
        tick(); in_data = 32'h2;
        tick(); in_valid = 1'b0;
        tick(); reset = 1'b1;
        #1;
        check("t1_occ_async", 32'(occupancy), 32'd0);
        check("t1_ov_async", 32'(out_valid), 32'd0);
        tick(); reset = 1'b0;
        @(negedge clk);
        check("t1_in_ready", 32'(in_ready), 32'd1);

        // Streaming 0xA0..0xA7 back to back
        tick(); out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'hA0 + 32'(i);
            if (i == 0) begin
                t_in    = cyc;
                lat_arm = 1'b1;
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("t2_drained", 32'(occupancy), 32'd0);
        check("t2_lat_seen", 32'(lat_arm), 32'd0);

        // Backpressure: exactly DEPTH words accepted, then drain in order
        tick(); out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA0;
        acc_cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (in_ready) acc_cnt++;
            tick();
            in_data = 32'hA0 + 32'(acc_cnt);
        end
        check("t3_accepted", 32'(acc_cnt), 32'd3);
        @(negedge clk);
        check("t3_full_occ", 32'(occupancy), 32'd3);
        check("t3_full_rdy", 32'(in_ready), 32'd0);
        tick(); in_valid = 1'b0; out_ready = 1'b1;
        repeat (5) tick();

        // Bubble: 0x11, idle, 0x22 with the consumer stalled
        out_ready = 1'b0; ls_out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h11; ls_in_valid = 1'b1; ls_in_data = 32'h11;
        tick(); in_valid = 1'b0; ls_in_valid = 1'b0;
        tick(); in_valid = 1'b1; in_data = 32'h22; ls_in_valid = 1'b1; ls_in_data = 32'h22;
        tick(); in_valid = 1'b0; ls_in_valid = 1'b0;
        @(negedge clk);
        check("t4_el_occ", 32'(occupancy), 32'd2);
        check("t4_el_rdy", 32'(in_ready), 32'd1);
        check("t4_ls_occ", 32'(ls_occupancy), 32'd2);
        check("t4_ls_ov", 32'(ls_out_valid), 32'd1);
        check("t4_ls_rdy", 32'(ls_in_ready), 32'd0);
        tick();
        @(negedge clk);
        check("t4_el_rdy2", 32'(in_ready), 32'd1);
        check("t4_ls_rdy2", 32'(ls_in_ready), 32'd0);
        tick(); out_ready = 1'b1; ls_out_ready = 1'b1;
        @(negedge clk);
        check("t4_ls_head", ls_out_data, 32'h11);
        tick();
        @(negedge clk);
        check("t4_ls_bubble", 32'(ls_out_valid), 32'd0);
        tick();
        @(negedge clk);
        check("t4_ls_ov2", 32'(ls_out_valid), 32'd1);
        check("t4_ls_tail", ls_out_data, 32'h22);
        tick(); repeat (3) tick();

        // Flush a full chain while input is offered
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hB0 + 32'(i);
            tick();
        end
        flush = 1'b1; in_data = 32'hEE;
        @(negedge clk);
        check("t5_flush_rdy", 32'(in_ready), 32'd0);
        tick(); flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("t5_ov", 32'(out_valid), 32'd0);
        check("t5_occ", 32'(occupancy), 32'd0);
        repeat (4) begin
            tick();
            @(negedge clk);
            check("t5_no_capture", 32'(out_valid), 32'd0);
        end

        // Flush together with a consumer handshake
        tick(); out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'hA0 + 32'(i);
            tick();
        end
        in_valid = 1'b0; flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("t6_head_ov", 32'(out_valid), 32'd1);
        check("t6_head_data", out_data, 32'hA0);
        tick(); flush = 1'b0;
        @(negedge clk);
        check("t6_occ", 32'(occupancy), 32'd0);
        check("t6_ov", 32'(out_valid), 32'd0);

        // Randomised traffic, stalls, flushes and resets
        for (int n = 0; n < 600; n++) begin
            tick();
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 99) == 0);
        end
        tick(); in_valid = 1'b0; flush = 1'b0; reset = 1'b0; out_ready = 1'b1;
        repeat (5) tick();
        @(negedge clk);
        check("final_empty", 32'(occupancy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
